// File: rtl/motor_move_ctrl.sv
// motor_move_ctrl: signed relative-move sequencer with per-step delay, abort and done pulse.
// Optional delay ramp enabled by defining MOVE_CTRL_ACCEL_EN. Rev 1.0
`default_nettype none

module motor_move_ctrl #(
    parameter int COUNT_W = 8,
    parameter int POS_W   = 8,
    parameter int DELAY_W = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               half_step,
    input  logic [COUNT_W-1:0] steps,
    input  logic [DELAY_W-1:0] delay_cycles,
    input  logic [POS_W-1:0]   pos_in,
    input  logic               abort,
    output logic               busy,
    output logic [POS_W-1:0]   pos_out,
    output logic               pos_we,
    output logic               done,
    output logic               aborted
);

    localparam logic [COUNT_W-1:0] MAG_ONE   = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] DELAY_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0]   POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0]   POS_TWO   = {{(POS_W-2){1'b0}}, 2'b10};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_STEP   = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t             state_q;
    logic               dir_q;
    logic               half_q;
    logic [COUNT_W-1:0] mag_q;
    logic [DELAY_W-1:0] base_q;
    logic [DELAY_W-1:0] cnt_q;
    logic [POS_W-1:0]   pos_q;
    logic               busy_q;
    logic [POS_W-1:0]   pos_out_q;
    logic               pos_we_q;
    logic               done_q;
    logic               aborted_q;

    logic [COUNT_W-1:0] mag_d;
    logic [DELAY_W-1:0] base_d;
    logic [POS_W-1:0]   step_amt_d;
    logic [POS_W-1:0]   pos_d;
    logic [DELAY_W-1:0] step_delay_d;

    // Two's-complement magnitude; the most negative value maps to 2^(COUNT_W-1) unsigned.
    assign mag_d      = steps[COUNT_W-1] ? ((~steps) + MAG_ONE) : steps;
    assign base_d     = (delay_cycles == '0) ? DELAY_ONE : delay_cycles;
    assign step_amt_d = half_q ? POS_ONE : POS_TWO;
    assign pos_d      = dir_q ? (pos_q - step_amt_d) : (pos_q + step_amt_d);

`ifdef MOVE_CTRL_ACCEL_EN
    logic [DELAY_W-1:0] cur_q;
    logic [DELAY_W+1:0] ramp_wide_d;
    logic [DELAY_W-1:0] ramp_init_d;
    logic [DELAY_W-1:0] ramp_half_d;
    logic [DELAY_W-1:0] ramp_next_d;

    // Ramp starts at 4x base, saturating at the counter's maximum.
    assign ramp_wide_d  = {2'b00, base_d} << 2;
    assign ramp_init_d  = (ramp_wide_d[DELAY_W+1:DELAY_W] != 2'b00) ? {DELAY_W{1'b1}}
                                                                      : ramp_wide_d[DELAY_W-1:0];
    assign ramp_half_d  = cur_q >> 1;
    assign ramp_next_d  = (ramp_half_d < base_q) ? base_q : ramp_half_d;
    assign step_delay_d = cur_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            cur_q <= ramp_init_d;
        end else if (state_q == S_STEP) begin
            cur_q <= ramp_next_d;
        end
    end
`else
    assign step_delay_d = base_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            mag_q     <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            pos_q     <= '0;
            busy_q    <= 1'b0;
            pos_out_q <= '0;
            pos_we_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            pos_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dir_q     <= steps[COUNT_W-1];
                        half_q    <= half_step;
                        mag_q     <= mag_d;
                        base_q    <= base_d;
                        pos_q     <= pos_in;
                        busy_q    <= 1'b1;
                        aborted_q <= 1'b0;
                        state_q   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        state_q   <= S_FINISH;
                    end else if (mag_q == '0) begin
                        done_q    <= 1'b1;
                        aborted_q <= 1'b0;
                        state_q   <= S_FINISH;
                    end else begin
                        // Outputs are registered, so the write is launched on entry to STEP.
                        pos_q     <= pos_d;
                        pos_out_q <= pos_d;
                        pos_we_q  <= 1'b1;
                        mag_q     <= mag_q - MAG_ONE;
                        state_q   <= S_STEP;
                    end
                end
                S_STEP: begin
                    cnt_q   <= step_delay_d;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (abort) begin
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        state_q   <= S_FINISH;
                    end else if (cnt_q == DELAY_ONE) begin
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q - DELAY_ONE;
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign pos_out = pos_out_q;
    assign pos_we  = pos_we_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

`default_nettype wire

// File: tb/tb_motor_move_ctrl.sv
// tb_motor_move_ctrl: randomized moves checked every cycle against a timeline model.
`default_nettype none

module tb_motor_move_ctrl;

    localparam int COUNT_W = 8;
    localparam int POS_W   = 8;
    localparam int DELAY_W = 20;
`ifdef MOVE_CTRL_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               half_step;
    logic [COUNT_W-1:0] steps;
    logic [DELAY_W-1:0] delay_cycles;
    logic [POS_W-1:0]   pos_in;
    logic               abort;
    logic               busy;
    logic [POS_W-1:0]   pos_out;
    logic               pos_we;
    logic               done;
    logic               aborted;

    motor_move_ctrl #(.COUNT_W(COUNT_W), .POS_W(POS_W), .DELAY_W(DELAY_W)) dut (
        .clk(clk), .reset(reset), .start(start), .half_step(half_step), .steps(steps),
        .delay_cycles(delay_cycles), .pos_in(pos_in), .abort(abort), .busy(busy),
        .pos_out(pos_out), .pos_we(pos_we), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    bit chk_en = 1'b0;

    // Model of the current move: absolute accept cycle, relative step cycles/positions, done cycle.
    bit mv_active = 1'b0;
    int mv_c, mv_done, mv_ab;
    int st_cyc[$];
    int st_pos[$];
    int idle_pos = 0;
    int idle_ab = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int r, eb, ed, ew, ep, ea;
        if (pos_we) we_cnt++;
        if (chk_en && !reset) begin
            eb = 0; ed = 0; ew = 0; ep = idle_pos; ea = idle_ab;
            if (mv_active) begin
                r = cyc - mv_c;
                eb = (r >= 1 && r <= mv_done) ? 1 : 0;
                ed = (r == mv_done) ? 1 : 0;
                foreach (st_cyc[i]) begin
                    if (st_cyc[i] == r) ew = 1;
                    if (st_cyc[i] <= r) ep = st_pos[i];
                end
                if (r >= 1) ea = (r >= mv_done) ? mv_ab : 0;
            end
            chk("busy", int'(busy), eb);
            chk("done", int'(done), ed);
            chk("pos_we", int'(pos_we), ew);
            chk("pos_out", int'(pos_out), ep);
            chk("aborted", int'(aborted), ea);
        end
    end

    // Timeline of a move from its operands: step k lands at a known cycle, WAITs last the delay.
    task automatic plan(input int s, input int half, input int dly, input int pin, input int abort_rel);
        int mag, inc, base, cur, pos, t, k;
        if (mv_active) begin
            if (st_pos.size() > 0) idle_pos = st_pos[st_pos.size()-1];
            idle_ab = mv_ab;
        end
        st_cyc.delete();
        st_pos.delete();
        mag  = (s < 0) ? -s : s;
        inc  = half ? 1 : 2;
        base = (dly == 0) ? 1 : dly;
        cur  = ACCEL ? ((base * 4 > 1048575) ? 1048575 : base * 4) : base;
        pos  = pin;
        t = 1;
        k = 0;
        while (1) begin
            if (abort_rel == t) begin mv_done = t + 1; mv_ab = 1; break; end
            if (k == mag) begin mv_done = t + 1; mv_ab = 0; break; end
            pos = (s < 0) ? (pos - inc + 256) % 256 : (pos + inc) % 256;
            st_cyc.push_back(t + 1);
            st_pos.push_back(pos);
            k++;
            if (abort_rel >= t + 2 && abort_rel <= t + 1 + cur) begin
                mv_done = abort_rel + 1; mv_ab = 1; break;
            end
            t = t + 2 + cur;
            if (ACCEL) cur = (cur / 2 < base) ? base : cur / 2;
        end
    endtask

    task automatic run_move(input int s, input int half, input int dly, input int pin,
                            input int abort_rel, input bit spur_en, input int reset_rel);
        int spur_rel;
        int sv;
        @(posedge clk); #1;
        plan(s, half, dly, pin, abort_rel);
        mv_c = cyc;
        mv_active = 1'b1;
        spur_rel = spur_en ? int'($urandom_range(1, mv_done)) : 0;
        sv = s;
        steps = sv[COUNT_W-1:0];
        half_step = half[0];
        delay_cycles = dly[DELAY_W-1:0];
        pos_in = pin[POS_W-1:0];
        abort = 1'b0;
        start = 1'b1;
        for (int r = 1; r <= mv_done + 1; r++) begin
            @(posedge clk); #1;
            start = (r == spur_rel);
            if (start) begin
                steps = COUNT_W'($urandom);
                half_step = 1'($urandom);
                delay_cycles = DELAY_W'($urandom_range(0, 3));
                pos_in = POS_W'($urandom);
            end
            abort = (r == abort_rel);
            if (r == reset_rel) begin
                #2 reset = 1'b1;
                #1;
                chk("rst_busy", int'(busy), 0);
                chk("rst_pos_out", int'(pos_out), 0);
                chk("rst_pos_we", int'(pos_we), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_aborted", int'(aborted), 0);
                mv_active = 1'b0;
                idle_pos = 0;
                idle_ab = 0;
                start = 1'b0;
                abort = 1'b0;
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int s, d, w0, ar;
        reset = 1'b1;
        start = 1'b0;
        half_step = 1'b0;
        steps = '0;
        delay_cycles = '0;
        pos_in = '0;
        abort = 1'b0;
        #2;
        chk("init_busy", int'(busy), 0);
        chk("init_pos_out", int'(pos_out), 0);
        chk("init_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Reset in the first WAIT of a 5-step move, then a fresh move must work.
        run_move(5, 0, 6, 20, 0, 1'b0, 5);
        run_move(2, 1, 2, 7, 0, 1'b0, 0);
        chk("post_rst_pos", int'(pos_out), 9);

        run_move(3, 0, 4, 10, 0, 1'b0, 0);
        chk("up_nsteps", st_cyc.size(), 3);
        chk("up_cyc1", st_cyc[1], 8);
        chk("up_pos2", st_pos[2], 16);
        chk("up_done", mv_done, 20);
        chk("up_dut_pos", int'(pos_out), 16);

        run_move(-2, 1, 0, 0, 0, 1'b1, 0);
        chk("wrap_pos0", st_pos[0], 255);
        chk("wrap_pos1", st_pos[1], 254);
        chk("wrap_cyc1", st_cyc[1], 5);
        chk("wrap_done", mv_done, 8);

        run_move(0, 0, 3, 77, 0, 1'b0, 0);
        chk("zero_done", mv_done, 2);
        chk("zero_nsteps", st_cyc.size(), 0);
        chk("zero_pos_hold", int'(pos_out), 254);

        w0 = we_cnt;
        run_move(-128, 1, 0, 0, 0, 1'b0, 0);
        chk("min_we_count", we_cnt - w0, 128);
        chk("min_pos", int'(pos_out), 128);

        run_move(10, 0, 8, 50, 25, 1'b1, 0);
        chk("abort_nsteps", st_cyc.size(), 3);
        chk("abort_done", mv_done, 26);
        chk("abort_flag", int'(aborted), 1);

        run_move(4, 0, 4, 0, 0, 1'b0, 0);
        chk("ramp_cyc1", st_cyc[1], ACCEL ? 20 : 8);
        chk("ramp_done", mv_done, ACCEL ? 42 : 26);

        for (int n = 0; n < 40; n++) begin
            s = $urandom_range(0, 10);
            if ($urandom_range(0, 1) == 1) s = -s;
            d = $urandom_range(0, 5);
            if ($urandom_range(0, 9) == 0) begin
                s = ($urandom_range(0, 1) == 1) ? -128 : 127;
                d = 0;
            end
            ar = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10 * (d + 3) + 2)) : 0;
            run_move(s, $urandom_range(0, 1), d, $urandom_range(0, 255), ar,
                     1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
